rgy_phase_sched: RTL and testbench

//  Demand-driven phase scheduler for a two-road intersection. Drives rgy0/rgy1

---
 rtl/rgy_pkg.sv | 55 +++++
 rtl/rgy_dwell_timer.sv | 39 +++
 rtl/rgy_phase_sched.sv | 115 +++++++++++
 tb/tb_rgy_phase_sched.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/rgy_pkg.sv
// Shared constants for the two-road phase scheduler: lamp bit positions,
// lamp vectors, phase encodings and small decode helpers.
package rgy_pkg;

    // Bit positions inside a 4-bit lamp vector (bit 3 is always 0).
    localparam int RED    = 0;
    localparam int YELLOW = 1;
    localparam int GREEN  = 2;

    localparam logic [3:0] LAMP_R = 4'(1 << RED);
    localparam logic [3:0] LAMP_Y = 4'(1 << YELLOW);
    localparam logic [3:0] LAMP_G = 4'(1 << GREEN);

    // Phase encodings are visible on the debug port, so they are fixed.
    typedef enum logic [2:0] {
        ST_G1  = 3'd0,
        ST_Y1  = 3'd1,
        ST_AR1 = 3'd2,
        ST_G0  = 3'd3,
        ST_Y0  = 3'd4,
        ST_AR0 = 3'd5
    } state_t;

    // Fixed rotation G1 -> Y1 -> AR1 -> G0 -> Y0 -> AR0 -> G1.
    // Unused encodings recover to G1.
    function automatic state_t next_phase(input state_t s);
        case (s)
            ST_G1:   return ST_Y1;
            ST_Y1:   return ST_AR1;
            ST_AR1:  return ST_G0;
            ST_G0:   return ST_Y0;
            ST_Y0:   return ST_AR0;
            default: return ST_G1;
        endcase
    endfunction

    // Lamp vector for one road in a given phase; anything not green or
    // yellow for that road shows red.
    function automatic logic [3:0] road_lamp(input state_t s, input logic road);
        if (road) begin
            case (s)
                ST_G1:   return LAMP_G;
                ST_Y1:   return LAMP_Y;
                default: return LAMP_R;
            endcase
        end else begin
            case (s)
                ST_G0:   return LAMP_G;
                ST_Y0:   return LAMP_Y;
                default: return LAMP_R;
            endcase
        end
    endfunction

endpackage

// File: rtl/rgy_dwell_timer.sv
// Phase dwell counter: clears on every phase change, counts up while the
// phase is held and saturates at the selected limit minus one.
module rgy_dwell_timer #(
    parameter int TW        = 4,
    parameter int GREEN_MIN = 4,
    parameter int GREEN_MAX = 12
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          clr,
    input  logic [TW-1:0] limit,
    output logic          at_min,
    output logic          at_max,
    output logic          at_dwell
);

    localparam logic [TW-1:0] MIN_LAST = TW'(GREEN_MIN - 1);
    localparam logic [TW-1:0] MAX_LAST = TW'(GREEN_MAX - 1);

    logic [TW-1:0] cnt_reg;
    logic [TW-1:0] last;

    assign last = limit - TW'(1);

    // Count cycles in the current phase; hold at the last dwell cycle so an
    // extended all-red hold cannot wrap around.
    always_ff @(posedge clk) begin
        if (srst || clr) begin
            cnt_reg <= '0;
        end else if (cnt_reg < last) begin
            cnt_reg <= cnt_reg + TW'(1);
        end
    end

    assign at_min   = (cnt_reg >= MIN_LAST);
    assign at_max   = (cnt_reg == MAX_LAST);
    assign at_dwell = (cnt_reg >= last);

endmodule

// File: rtl/rgy_phase_sched.sv
// Demand-driven two-road phase scheduler with all-red clearance, latched
// pedestrian walk service and an emergency all-red hold.
module rgy_phase_sched
    import rgy_pkg::*;
#(
    parameter int TW        = 4,
    parameter int GREEN_MIN = 4,
    parameter int GREEN_MAX = 12,
    parameter int YELLOW_T  = 2,
    parameter int ALLRED_T  = 1,
    parameter int WALK_T    = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    input  logic       ped_req,
    input  logic       force_red,
    output logic [3:0] rgy0,
    output logic [3:0] rgy1,
    output logic       ped_walk,
    output logic [2:0] phase
);

    state_t        state_reg;
    state_t        state_next;
    logic          ped_pend_reg;
    logic          walk_reg;
    logic [3:0]    rgy0_reg;
    logic [3:0]    rgy1_reg;

    logic          advance;
    logic          in_yellow;
    logic          in_allred;
    logic          serve;
    logic [TW-1:0] limit;
    logic          at_min;
    logic          at_max;
    logic          at_dwell;

    rgy_dwell_timer #(
        .TW        (TW),
        .GREEN_MIN (GREEN_MIN),
        .GREEN_MAX (GREEN_MAX)
    ) u_timer (
        .clk      (clk),
        .srst     (reset),
        .clr      (advance),
        .limit    (limit),
        .at_min   (at_min),
        .at_max   (at_max),
        .at_dwell (at_dwell)
    );

    // Phase exit conditions and dwell limit for the current phase.
    always_comb begin
        limit     = TW'(GREEN_MAX);
        advance   = 1'b0;
        in_yellow = 1'b0;
        in_allred = 1'b0;
        case (state_reg)
            ST_G1: begin
                advance = force_red | at_max | (at_min & (req0 | ped_pend_reg));
            end
            ST_G0: begin
                advance = force_red | at_max | (at_min & (req1 | ped_pend_reg));
            end
            ST_Y1, ST_Y0: begin
                limit     = TW'(YELLOW_T);
                in_yellow = 1'b1;
                advance   = at_dwell;
            end
            ST_AR1, ST_AR0: begin
                limit     = walk_reg ? TW'(WALK_T) : TW'(ALLRED_T);
                in_allred = 1'b1;
                advance   = at_dwell & ~force_red;
            end
            default: begin
                advance = 1'b1;
            end
        endcase
        state_next = advance ? next_phase(state_reg) : state_reg;
        // A pending pedestrian is served on the yellow -> all-red step.
        serve = advance & in_yellow & ped_pend_reg;
    end

    // Phase register, pedestrian latch, walk flag and registered lamp outputs
    // (lamps are decoded from the next phase so they track the state exactly).
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_G1;
            ped_pend_reg <= 1'b0;
            walk_reg     <= 1'b0;
            rgy0_reg     <= LAMP_R;
            rgy1_reg     <= LAMP_G;
        end else begin
            state_reg    <= state_next;
            // A new press in the serving cycle keeps the request pending.
            ped_pend_reg <= ped_req | (ped_pend_reg & ~serve);
            if (advance && in_yellow) begin
                walk_reg <= ped_pend_reg;
            end else if (advance && in_allred) begin
                walk_reg <= 1'b0;
            end
            rgy0_reg <= road_lamp(state_next, 1'b0);
            rgy1_reg <= road_lamp(state_next, 1'b1);
        end
    end

    assign rgy0     = rgy0_reg;
    assign rgy1     = rgy1_reg;
    assign ped_walk = walk_reg;
    assign phase    = state_reg;

endmodule

// File: tb/tb_rgy_phase_sched.sv
// Directed bench for rgy_phase_sched: hand-timed phase sequences followed by
// a random invariant soak.
module tb_rgy_phase_sched;

    localparam logic [2:0] P_G1  = 3'd0;
    localparam logic [2:0] P_Y1  = 3'd1;
    localparam logic [2:0] P_AR1 = 3'd2;
    localparam logic [2:0] P_G0  = 3'd3;
    localparam logic [2:0] P_Y0  = 3'd4;
    localparam logic [2:0] P_AR0 = 3'd5;
    localparam logic [3:0] L_R   = 4'b0001;
    localparam logic [3:0] L_Y   = 4'b0010;
    localparam logic [3:0] L_G   = 4'b0100;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req0 = 1'b0;
    logic       req1 = 1'b0;
    logic       ped_req = 1'b0;
    logic       force_red = 1'b0;
    logic [3:0] rgy0;
    logic [3:0] rgy1;
    logic       ped_walk;
    logic [2:0] phase;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    rgy_phase_sched #(
        .TW        (4),
        .GREEN_MIN (4),
        .GREEN_MAX (12),
        .YELLOW_T  (2),
        .ALLRED_T  (1),
        .WALK_T    (6)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .req1      (req1),
        .ped_req   (ped_req),
        .force_red (force_red),
        .rgy0      (rgy0),
        .rgy1      (rgy1),
        .ped_walk  (ped_walk),
        .phase     (phase)
    );

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    // Check n consecutive cycles of one phase, then leave the bench at the
    // sample point of the following cycle.
    task automatic run(input string tag, input logic [2:0] ph, input logic [3:0] r0,
                       input logic [3:0] r1, input logic w, input int n);
        for (int i = 0; i < n; i++) begin
            chk({tag, ".phase"}, 4'(phase), 4'(ph));
            chk({tag, ".rgy0"}, rgy0, r0);
            chk({tag, ".rgy1"}, rgy1, r1);
            chk({tag, ".walk"}, 4'(ped_walk), 4'(w));
            step();
        end
    endtask

    // Hold reset for n edges; returns at the sample point of cycle 0.
    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) step();
        reset = 1'b0;
        cyc = 0;
    endtask

    initial begin
        logic [2:0] prev_ph;
        int         glen;
        bit         forced;
        bit         is_g;
        bit         is_ar;
        bit         prev_g;

        // T1: reset values, then an idle full rotation.
        reset = 1'b1;
        step();
        chk("t1.rst_phase", 4'(phase), 4'(P_G1));
        chk("t1.rst_rgy0", rgy0, L_R);
        chk("t1.rst_rgy1", rgy1, L_G);
        chk("t1.rst_walk", 4'(ped_walk), 4'd0);
        do_reset(2);
        run("t1.g1", P_G1, L_R, L_G, 1'b0, 12);
        run("t1.y1", P_Y1, L_R, L_Y, 1'b0, 2);
        run("t1.ar1", P_AR1, L_R, L_R, 1'b0, 1);
        run("t1.g0", P_G0, L_G, L_R, 1'b0, 12);
        run("t1.y0", P_Y0, L_Y, L_R, 1'b0, 2);
        run("t1.ar0", P_AR0, L_R, L_R, 1'b0, 1);
        run("t1.g1b", P_G1, L_R, L_G, 1'b0, 1);

        // T2: opposing demand cuts green to the minimum.
        req0 = 1'b1;
        do_reset(2);
        run("t2.g1", P_G1, L_R, L_G, 1'b0, 4);
        run("t2.y1", P_Y1, L_R, L_Y, 1'b0, 2);
        run("t2.ar1", P_AR1, L_R, L_R, 1'b0, 1);
        req0 = 1'b0;
        run("t2.g0", P_G0, L_G, L_R, 1'b0, 1);

        // T3: pedestrian pulse at cycle 2 gives a 6-cycle walk all-red.
        do_reset(2);
        run("t3.g1a", P_G1, L_R, L_G, 1'b0, 2);
        ped_req = 1'b1;
        run("t3.g1b", P_G1, L_R, L_G, 1'b0, 1);
        ped_req = 1'b0;
        run("t3.g1c", P_G1, L_R, L_G, 1'b0, 1);
        run("t3.y1", P_Y1, L_R, L_Y, 1'b0, 2);
        run("t3.ar1", P_AR1, L_R, L_R, 1'b1, 6);
        run("t3.g0", P_G0, L_G, L_R, 1'b0, 1);

        // T3b: a press in the serving cycle stays pending for the next all-red.
        do_reset(2);
        ped_req = 1'b1;
        run("t3b.g1a", P_G1, L_R, L_G, 1'b0, 1);
        ped_req = 1'b0;
        run("t3b.g1b", P_G1, L_R, L_G, 1'b0, 3);
        run("t3b.y1a", P_Y1, L_R, L_Y, 1'b0, 1);
        ped_req = 1'b1;
        run("t3b.y1b", P_Y1, L_R, L_Y, 1'b0, 1);
        ped_req = 1'b0;
        run("t3b.ar1", P_AR1, L_R, L_R, 1'b1, 6);
        run("t3b.g0", P_G0, L_G, L_R, 1'b0, 4);
        run("t3b.y0", P_Y0, L_Y, L_R, 1'b0, 2);
        run("t3b.ar0", P_AR0, L_R, L_R, 1'b1, 6);
        run("t3b.g1", P_G1, L_R, L_G, 1'b0, 1);

        // T4: force_red at cnt=1 of G1, yellow completes, all-red held.
        do_reset(2);
        run("t4.g1a", P_G1, L_R, L_G, 1'b0, 1);
        force_red = 1'b1;
        run("t4.g1b", P_G1, L_R, L_G, 1'b0, 1);
        run("t4.y1", P_Y1, L_R, L_Y, 1'b0, 2);
        run("t4.ar1hold", P_AR1, L_R, L_R, 1'b0, 5);
        force_red = 1'b0;
        run("t4.ar1rel", P_AR1, L_R, L_R, 1'b0, 1);
        run("t4.g0", P_G0, L_G, L_R, 1'b0, 1);

        // T5: reset in the middle of Y0 with a pedestrian pending.
        req0 = 1'b1;
        req1 = 1'b1;
        do_reset(2);
        run("t5.g1", P_G1, L_R, L_G, 1'b0, 4);
        run("t5.y1", P_Y1, L_R, L_Y, 1'b0, 2);
        run("t5.ar1", P_AR1, L_R, L_R, 1'b0, 1);
        run("t5.g0", P_G0, L_G, L_R, 1'b0, 4);
        ped_req = 1'b1;
        run("t5.y0a", P_Y0, L_Y, L_R, 1'b0, 1);
        ped_req = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        chk("t5.pre_reset", 4'(phase), 4'(P_Y0));
        reset = 1'b1;
        step();
        reset = 1'b0;
        cyc = 0;
        run("t5.g1_after", P_G1, L_R, L_G, 1'b0, 12);
        run("t5.y1_after", P_Y1, L_R, L_Y, 1'b0, 2);
        run("t5.ar1_after", P_AR1, L_R, L_R, 1'b0, 1);
        run("t5.g0_after", P_G0, L_G, L_R, 1'b0, 1);

        // T6: random inputs, invariant checks every cycle.
        do_reset(2);
        prev_ph = phase;
        prev_g  = 1'b0;
        glen    = 0;
        forced  = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            is_g  = (phase == P_G1) || (phase == P_G0);
            is_ar = (phase == P_AR1) || (phase == P_AR0);
            chk("rnd.conflict", 4'((rgy0 != L_R) && (rgy1 != L_R)), 4'd0);
            chk("rnd.walk_ar", 4'(ped_walk && !is_ar), 4'd0);
            chk("rnd.g2g", 4'(prev_g && is_g && (phase != prev_ph)), 4'd0);
            chk("rnd.legal", 4'(phase > P_AR0), 4'd0);
            if (!is_g && glen > 0) begin
                if (!forced) begin
                    chk("rnd.green_min", 4'(glen >= 4), 4'd1);
                end
                glen   = 0;
                forced = 1'b0;
            end
            if (is_g) begin
                glen++;
            end
            req0      = ($urandom_range(0, 3) == 0);
            req1      = ($urandom_range(0, 3) == 0);
            ped_req   = ($urandom_range(0, 15) == 0);
            force_red = ($urandom_range(0, 19) == 0);
            if (is_g && force_red) begin
                forced = 1'b1;
            end
            prev_ph = phase;
            prev_g  = is_g;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
